// File: rtl/sys_timer_pkg.sv
// Shared definitions for the timer scheduler: interval-timer register map,
// control bit positions, sequencer state encoding and the load-value helper.
package sys_timer_pkg;

    localparam int TMR_PW = 32;

    localparam logic [2:0] ADDR_STATUS   = 3'd0;
    localparam logic [2:0] ADDR_CONTROL  = 3'd1;
    localparam logic [2:0] ADDR_PERIOD_L = 3'd2;
    localparam logic [2:0] ADDR_PERIOD_H = 3'd3;
    localparam logic [2:0] ADDR_SNAP_L   = 3'd4;
    localparam logic [2:0] ADDR_SNAP_H   = 3'd5;

    localparam int CTRL_ITO   = 0;
    localparam int CTRL_CONT  = 1;
    localparam int CTRL_START = 2;
    localparam int CTRL_STOP  = 3;

    // One-shot start with interrupt enabled (CONT left clear), and a plain
    // stop that also masks the interrupt.
    localparam logic [15:0] CTRL_WORD_START = (16'd1 << CTRL_START) | (16'd1 << CTRL_ITO);
    localparam logic [15:0] CTRL_WORD_STOP  = (16'd1 << CTRL_STOP);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_PL   = 3'd1,
        WR_PH   = 3'd2,
        WR_CTRL = 3'd3,
        WAIT    = 3'd4,
        STOP    = 3'd5,
        CLR     = 3'd6,
        RELEASE = 3'd7
    } sched_state_t;

    // The timer counts L down to 0 and times out one cycle later, so L = P-1.
    // Periods below 2 are raised to 2 so the counter never starts at 0.
    function automatic logic [TMR_PW-1:0] calc_load(input logic [TMR_PW-1:0] period);
        return (period < 32'd2) ? 32'd1 : period - 32'd1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the lowest requesting index at or above
// rr_ptr, wrapping past N_REQ-1 back to 0. Purely combinational, one-hot grant.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] rr_ptr,
    output logic [N_REQ-1:0] grant
);

    localparam int SW = PTR_W + 1;

    logic [SW-1:0]    sum;
    logic [PTR_W-1:0] idx;
    logic             found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        sum   = '0;
        idx   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            sum = {1'b0, rr_ptr} + SW'(i);
            if (sum >= SW'(N_REQ)) begin
                sum = sum - SW'(N_REQ);
            end
            idx = sum[PTR_W-1:0];
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sys_timer_scheduler.sv
// Shares one Avalon-MM interval timer among N_REQ one-shot delay requesters:
// round-robin grant, program period and start, wait for irq, clear, pulse done.
//
// state   | meaning
// IDLE    | timer free, arbitrate on req
// WR_PL   | write period_l = L[15:0]
// WR_PH   | write period_h = L[31:16]
// WR_CTRL | write control = START|ITO (lands on the timer's reload cycle)
// WAIT    | timer running; irq ends normally, owner dropping req cancels
// STOP    | cancel path: write control = STOP, interrupt masked
// CLR     | write status = 0 to clear timeout_occurred
// RELEASE | pulse done (unless cancelled), free the timer, advance rr_ptr
module sys_timer_scheduler
    import sys_timer_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int PW    = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [N_REQ-1:0]      req,
    input  logic [N_REQ*PW-1:0]   req_period,
    output logic [N_REQ-1:0]      active,
    output logic [N_REQ-1:0]      done,
    output logic                  busy,
    output logic [2:0]            tmr_address,
    output logic                  tmr_chipselect,
    output logic                  tmr_write_n,
    output logic [15:0]           tmr_writedata,
    input  logic                  tmr_irq
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    sched_state_t     state_q;
    sched_state_t     state_nxt;
    logic [PTR_W-1:0] rr_ptr_q;
    logic [PTR_W-1:0] owner_idx;
    logic [PTR_W-1:0] rr_ptr_nxt;
    logic [N_REQ-1:0] grant;
    logic [PW-1:0]    sel_period;
    logic [PW-1:0]    load_q;
    logic [PW-1:0]    load_nxt;
    logic             cancel_q;
    logic             owner_req;

    logic             cs_nxt;
    logic             wn_nxt;
    logic [2:0]       addr_nxt;
    logic [15:0]      wdata_nxt;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_arb (
        .req    (req),
        .rr_ptr (rr_ptr_q),
        .grant  (grant)
    );

    always_comb begin
        sel_period = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                sel_period = req_period[i*PW +: PW];
            end
        end
    end

    always_comb begin
        owner_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (active[i]) begin
                owner_idx = PTR_W'(i);
            end
        end
    end

    assign rr_ptr_nxt = (owner_idx == PTR_W'(N_REQ - 1)) ? '0 : owner_idx + 1'b1;
    assign owner_req  = |(req & active);

    // In IDLE the period comes straight from the winner so the first bus write
    // can leave on the grant edge; afterwards the latched value is used.
    assign load_nxt = (state_q == IDLE) ? calc_load(sel_period) : load_q;

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            IDLE:    if (|req) state_nxt = WR_PL;
            WR_PL:   state_nxt = WR_PH;
            WR_PH:   state_nxt = WR_CTRL;
            WR_CTRL: state_nxt = WAIT;
            WAIT: begin
                if (tmr_irq) begin
                    state_nxt = CLR;
                end else if (!owner_req) begin
                    state_nxt = STOP;
                end
            end
            STOP:    state_nxt = CLR;
            CLR:     state_nxt = RELEASE;
            RELEASE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Bus signals are decoded from the next state and registered, so each
    // write is on the bus for exactly the cycle its state is current.
    always_comb begin
        cs_nxt    = 1'b0;
        wn_nxt    = 1'b1;
        addr_nxt  = ADDR_STATUS;
        wdata_nxt = '0;
        case (state_nxt)
            WR_PL: begin
                cs_nxt    = 1'b1;
                wn_nxt    = 1'b0;
                addr_nxt  = ADDR_PERIOD_L;
                wdata_nxt = load_nxt[15:0];
            end
            WR_PH: begin
                cs_nxt    = 1'b1;
                wn_nxt    = 1'b0;
                addr_nxt  = ADDR_PERIOD_H;
                wdata_nxt = load_nxt[31:16];
            end
            WR_CTRL: begin
                cs_nxt    = 1'b1;
                wn_nxt    = 1'b0;
                addr_nxt  = ADDR_CONTROL;
                wdata_nxt = CTRL_WORD_START;
            end
            STOP: begin
                cs_nxt    = 1'b1;
                wn_nxt    = 1'b0;
                addr_nxt  = ADDR_CONTROL;
                wdata_nxt = CTRL_WORD_STOP;
            end
            CLR: begin
                cs_nxt    = 1'b1;
                wn_nxt    = 1'b0;
                addr_nxt  = ADDR_STATUS;
                wdata_nxt = 16'h0000;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            rr_ptr_q       <= '0;
            load_q         <= '0;
            cancel_q       <= 1'b0;
            active         <= '0;
            done           <= '0;
            busy           <= 1'b0;
            tmr_address    <= ADDR_STATUS;
            tmr_chipselect <= 1'b0;
            tmr_write_n    <= 1'b1;
            tmr_writedata  <= '0;
        end else begin
            state_q        <= state_nxt;
            busy           <= (state_nxt != IDLE);
            tmr_address    <= addr_nxt;
            tmr_chipselect <= cs_nxt;
            tmr_write_n    <= wn_nxt;
            tmr_writedata  <= wdata_nxt;
            done           <= (state_nxt == RELEASE && !cancel_q) ? active : '0;

            if (state_q == IDLE && (|req)) begin
                active   <= grant;
                load_q   <= load_nxt;
                cancel_q <= 1'b0;
            end
            if (state_q == WAIT && state_nxt == STOP) begin
                cancel_q <= 1'b1;
            end
            if (state_q == RELEASE) begin
                active   <= '0;
                rr_ptr_q <= rr_ptr_nxt;
            end
        end
    end

endmodule

// File: tb/tb_sys_timer_scheduler.sv
// Scoreboard bench for sys_timer_scheduler with a behavioural interval timer
// on its slave port; directed scenarios push expected writes/dones, a monitor checks.
module tb_sys_timer_scheduler;

    localparam int N  = 4;
    localparam int PW = 32;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [N-1:0]    req;
    logic [N*PW-1:0] req_period;
    logic [N-1:0]    active;
    logic [N-1:0]    done;
    logic            busy;
    logic [2:0]      tmr_address;
    logic            tmr_chipselect;
    logic            tmr_write_n;
    logic [15:0]     tmr_writedata;
    logic            tmr_irq;

    sys_timer_scheduler #(.N_REQ(N), .PW(PW)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .req            (req),
        .req_period     (req_period),
        .active         (active),
        .done           (done),
        .busy           (busy),
        .tmr_address    (tmr_address),
        .tmr_chipselect (tmr_chipselect),
        .tmr_write_n    (tmr_write_n),
        .tmr_writedata  (tmr_writedata),
        .tmr_irq        (tmr_irq)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Interval timer: period writes reload the counter one cycle later; START
    // loads the counter from period and runs; count L..0, then timeout.
    logic [15:0] t_pl, t_ph;
    logic        t_ito, t_cont, t_to, t_run, t_reload;
    logic [31:0] t_cnt;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            t_pl <= '0; t_ph <= '0; t_ito <= 1'b0; t_cont <= 1'b0;
            t_to <= 1'b0; t_run <= 1'b0; t_reload <= 1'b0; t_cnt <= '0;
        end else begin
            t_reload <= 1'b0;
            if (t_run && !t_reload) begin
                if (t_cnt == 32'd0) begin
                    t_to  <= 1'b1;
                    t_cnt <= {t_ph, t_pl};
                    if (!t_cont) t_run <= 1'b0;
                end else begin
                    t_cnt <= t_cnt - 32'd1;
                end
            end
            if (t_reload) t_cnt <= {t_ph, t_pl};
            if (tmr_chipselect && !tmr_write_n) begin
                case (tmr_address)
                    3'd0: t_to <= 1'b0;
                    3'd1: begin
                        t_ito  <= tmr_writedata[0];
                        t_cont <= tmr_writedata[1];
                        if (tmr_writedata[2]) begin
                            t_run <= 1'b1;
                            t_cnt <= {t_ph, t_pl};
                        end
                        if (tmr_writedata[3]) t_run <= 1'b0;
                    end
                    3'd2: begin t_pl <= tmr_writedata; t_reload <= 1'b1; end
                    3'd3: begin t_ph <= tmr_writedata; t_reload <= 1'b1; end
                    default: ;
                endcase
            end
        end
    end

    assign tmr_irq = t_to & t_ito;

    typedef struct { logic [2:0] addr; logic [15:0] data; } wr_t;
    typedef struct { int idx; int cyc; } dn_t;
    typedef struct { string tag; logic [9:0] exp; } st_t;

    wr_t   exp_wr[$];
    dn_t   exp_done[$];
    st_t   st_q[$];
    string tmo_q[$];
    logic  end_req = 1'b0;
    int    n_pass  = 0;
    int    n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: consumes expectations as the DUT presents bus writes and done pulses.
    always @(negedge clk) begin
        wr_t w;
        dn_t d;
        st_t s;
        if (tmr_chipselect && !tmr_write_n) begin
            if (exp_wr.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_write: got addr %0d data %h expected none (cycle %0d)",
                         tmr_address, tmr_writedata, cyc);
            end else begin
                w = exp_wr.pop_front();
                chk("tmr_write", 32'({tmr_address, tmr_writedata}), 32'({w.addr, w.data}));
            end
        end
        if (done != '0) begin
            if (exp_done.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_done: got %b expected none (cycle %0d)", done, cyc);
            end else begin
                d = exp_done.pop_front();
                chk("done_vec", 32'(done), 32'(1) << d.idx);
                chk("done_cycle", 32'(cyc), 32'(d.cyc));
                chk("active_at_done", 32'(active), 32'(1) << d.idx);
            end
        end
        if (st_q.size() != 0) begin
            s = st_q.pop_front();
            chk(s.tag, 32'({busy, active, tmr_write_n, tmr_chipselect, tmr_irq, t_to, t_run}),
                32'(s.exp));
        end
        while (tmo_q.size() != 0) begin
            n_total++;
            $display("FAIL timeout %s: got still busy expected idle (cycle %0d)", tmo_q.pop_front(), cyc);
        end
        if (cyc > 4000) begin
            n_total++;
            $display("FAIL watchdog: got cycle %0d expected end of run", cyc);
            $display("%0d/%0d checks passed", n_pass, n_total);
            $fatal(1, "watchdog");
        end
        if (end_req) begin
            chk("leftover_writes", 32'(exp_wr.size()), 32'd0);
            chk("leftover_dones", 32'(exp_done.size()), 32'd0);
            $display("%0d/%0d checks passed", n_pass, n_total);
            $finish;
        end
    end

    function automatic void exp_w(input logic [2:0] a, input logic [15:0] d);
        wr_t w;
        w.addr = a;
        w.data = d;
        exp_wr.push_back(w);
    endfunction

    function automatic void exp_d(input int idx, input int at);
        dn_t d;
        d.idx = idx;
        d.cyc = at;
        exp_done.push_back(d);
    endfunction

    // Full normal sequence: PL, PH, start, status clear, then done.
    function automatic void exp_normal(input int idx, input logic [15:0] pl, input logic [15:0] ph,
                                       input int at);
        exp_w(3'd2, pl);
        exp_w(3'd3, ph);
        exp_w(3'd1, 16'h0005);
        exp_w(3'd0, 16'h0000);
        exp_d(idx, at);
    endfunction

    function automatic void exp_cancel(input logic [15:0] pl, input logic [15:0] ph);
        exp_w(3'd2, pl);
        exp_w(3'd3, ph);
        exp_w(3'd1, 16'h0005);
        exp_w(3'd1, 16'h0008);
        exp_w(3'd0, 16'h0000);
    endfunction

    // Expected {busy, active, write_n, chipselect, irq, timeout, running}.
    task automatic check_state(input string tag, input logic b, input logic [3:0] a,
                               input logic wn, input logic cs, input logic irq,
                               input logic to, input logic run);
        st_t s;
        @(posedge clk);
        #1;
        s.tag = tag;
        s.exp = {b, a, wn, cs, irq, to, run};
        st_q.push_back(s);
        @(negedge clk);
        #1;
    endtask

    // Requesters drop their req on their own done pulse.
    task automatic wait_idle(input int bound, input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            req = req & ~done;
            n++;
        end while ((busy || req != '0) && n < bound);
        if (n >= bound) tmo_q.push_back(tag);
    endtask

    task automatic set_p(input int idx, input logic [31:0] p);
        req_period[idx*PW +: PW] = p;
    endtask

    // Timing reference: req driven at a negedge when cyc == c; that is the
    // grant cycle 0. A delay P finishes with done seen at cyc == c + P + 6,
    // and back-to-back services are spaced P + 7 cycles apart.
    initial begin
        int c;
        reset_n    = 1'b0;
        req        = '0;
        req_period = '0;
        repeat (2) @(negedge clk);
        check_state("reset_state", 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        reset_n = 1'b1;

        // Contention: all four at once, P=10, L=9, served 0..3
        @(negedge clk);
        c = cyc;
        for (int i = 0; i < N; i++) set_p(i, 32'd10);
        req = 4'b1111;
        exp_normal(0, 16'h0009, 16'h0000, c + 16);
        exp_normal(1, 16'h0009, 16'h0000, c + 33);
        exp_normal(2, 16'h0009, 16'h0000, c + 50);
        exp_normal(3, 16'h0009, 16'h0000, c + 67);
        wait_idle(300, "contention");

        // Owner 3 alone, then 0 and 3 together: pointer wrapped to 0
        @(negedge clk);
        c = cyc;
        req = 4'b1000;
        exp_normal(3, 16'h0009, 16'h0000, c + 16);
        wait_idle(100, "owner3");
        @(negedge clk);
        c = cyc;
        req = 4'b1001;
        exp_normal(0, 16'h0009, 16'h0000, c + 16);
        exp_normal(3, 16'h0009, 16'h0000, c + 33);
        wait_idle(200, "rr_wrap");

        // Single P=100; period changed after grant must not matter
        @(negedge clk);
        c = cyc;
        set_p(0, 32'd100);
        req = 4'b0001;
        exp_normal(0, 16'h0063, 16'h0000, c + 106);
        repeat (3) @(negedge clk);
        set_p(0, 32'd5);
        wait_idle(300, "single");
        check_state("single_status_clear", 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // irq and req drop in the same cycle: irq wins, done still pulsed
        @(negedge clk);
        c = cyc;
        set_p(1, 32'd20);
        req = 4'b0010;
        exp_normal(1, 16'h0013, 16'h0000, c + 26);
        while (cyc < c + 24) @(negedge clk);
        req[1] = 1'b0;
        wait_idle(100, "irq_vs_drop");

        // Clamp: P=0 behaves as P=2
        @(negedge clk);
        c = cyc;
        set_p(2, 32'd0);
        req = 4'b0100;
        exp_normal(2, 16'h0001, 16'h0000, c + 8);
        wait_idle(100, "clamp");

        // Wide period 100000 -> L=0x0001869F; cancelled after 30 cycles
        @(negedge clk);
        c = cyc;
        set_p(3, 32'h0001_86A0);
        req = 4'b1000;
        exp_cancel(16'h869F, 16'h0001);
        while (cyc < c + 30) @(negedge clk);
        req[3] = 1'b0;
        wait_idle(100, "wide_cancel");

        // Cancel: req[2] P=1000 dropped at 50 cycles
        @(negedge clk);
        c = cyc;
        set_p(2, 32'd1000);
        req = 4'b0100;
        exp_cancel(16'h03E7, 16'h0000);
        while (cyc < c + 50) @(negedge clk);
        req[2] = 1'b0;
        wait_idle(100, "cancel");
        check_state("cancel_timer_idle", 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset in WAIT, then a fresh request
        @(negedge clk);
        c = cyc;
        set_p(1, 32'd500);
        req = 4'b0010;
        exp_w(3'd2, 16'h01F3);
        exp_w(3'd3, 16'h0000);
        exp_w(3'd1, 16'h0005);
        while (cyc < c + 20) @(negedge clk);
        check_state("in_wait", 1'b1, 4'b0010, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        reset_n = 1'b0;
        req     = '0;
        check_state("midwait_reset", 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        c = cyc;
        set_p(1, 32'd20);
        req = 4'b0010;
        exp_normal(1, 16'h0013, 16'h0000, c + 26);
        wait_idle(100, "after_reset");
        check_state("final_idle", 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        end_req = 1'b1;
    end

endmodule
